// File: rtl/fs_pkg.sv
// Shared definitions for the digit-serial full subtractor: state encodings,
// counter-width helper and a parameter legality check.
package fs_pkg;

  typedef enum logic {
    FS_ST_IDLE = 1'b0,
    FS_ST_RUN  = 1'b1
  } fs_state_e;

  // Counter width for n digits; never narrower than one bit.
  function automatic int fs_clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit fs_div_ok(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/fs_digit.sv
// Combinational WIDTH-bit full subtractor: {borrow_out, sub} = in0 - in1 - borrow_in.
// Zero latency, no flow control.
module fs_digit #(
  parameter int WIDTH = 8
) (
  input  logic             borrow_in,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] sub,
  output logic             borrow_out
);

  // One extra bit catches the borrow: it is set exactly when in0 < in1 + borrow_in.
  logic [WIDTH:0] diff;

  assign diff       = {1'b0, in0} - {1'b0, in1} - {{WIDTH{1'b0}}, borrow_in};
  assign sub        = diff[WIDTH-1:0];
  assign borrow_out = diff[WIDTH];

endmodule

// File: rtl/fs_ds_nb.sv
// Digit-serial WIDTH-bit subtractor, DIGIT bits per cycle; done pulses NDIG edges after start is taken.
// start is only sampled while idle (busy=0); requests during a run are dropped.
module fs_ds_nb
  import fs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             borrow_in,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sub,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = fs_clog2_min1(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (!fs_div_ok(WIDTH, DIGIT)) begin : g_bad_param
      $error("fs_ds_nb: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  fs_state_e        state_q, state_d;
  logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
  logic             brw, a_sgn, b_sgn;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dig_sub;
  logic             dig_brw;
  logic             accept, last, finish;

  fs_digit #(.WIDTH(DIGIT)) u_digit (
    .borrow_in (brw),
    .in0       (op_a[DIGIT-1:0]),
    .in1       (op_b[DIGIT-1:0]),
    .sub       (dig_sub),
    .borrow_out(dig_brw)
  );

  // Each new digit enters at the top so after NDIG steps digit 0 sits at the bottom.
  generate
    if (NDIG == 1) begin : g_acc_single
      assign acc_nxt = dig_sub;
    end else begin : g_acc_shift
      assign acc_nxt = {dig_sub, acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign busy   = (state_q == FS_ST_RUN);
  assign accept = (state_q == FS_ST_IDLE) && start;
  assign last   = (cnt == LAST);
  assign finish = busy && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_ST_IDLE: if (start) state_d = FS_ST_RUN;
      FS_ST_RUN:  if (last)  state_d = FS_ST_IDLE;
      default:    state_d = FS_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      a_sgn      <= 1'b0;
      b_sgn      <= 1'b0;
      done       <= 1'b0;
      sub        <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        op_a  <= in0;
        op_b  <= in1;
        brw   <= borrow_in;
        cnt   <= '0;
        a_sgn <= in0[WIDTH-1];
        b_sgn <= in1[WIDTH-1];
      end else if (busy) begin
        op_a <= op_a >> DIGIT;
        op_b <= op_b >> DIGIT;
        acc  <= acc_nxt;
        brw  <= dig_brw;
        cnt  <= cnt + 1'b1;
      end
      // Result and flags are taken from the same final accumulator value.
      if (finish) begin
        sub        <= acc_nxt;
        borrow_out <= dig_brw;
        overflow   <= (a_sgn ^ b_sgn) & (acc_nxt[WIDTH-1] ^ a_sgn);
        zero       <= (acc_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_fs_ds_nb.sv
// Directed bench for fs_ds_nb: a 32/8 instance and a 32/32 single-digit instance.
module tb_fs_ds_nb;

  logic        clk = 1'b0;
  logic        rst_n, start, start1, borrow_in;
  logic [31:0] in0, in1;
  logic        busy, done, borrow_out, overflow, zero;
  logic [31:0] sub;
  logic        busy1, done1, borrow_out1, overflow1, zero1;
  logic [31:0] sub1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fs_ds_nb #(.WIDTH(32), .DIGIT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .borrow_in(borrow_in),
    .in0(in0), .in1(in1), .busy(busy), .done(done), .sub(sub),
    .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
  );

  fs_ds_nb #(.WIDTH(32), .DIGIT(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .borrow_in(borrow_in),
    .in0(in0), .in1(in1), .busy(busy1), .done(done1), .sub(sub1),
    .borrow_out(borrow_out1), .overflow(overflow1), .zero(zero1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one op and checks latency, result and flags.
  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input logic bi, input logic [31:0] exp_sub, input logic exp_bo,
                        input logic exp_ov, input logic exp_z, input int exp_lat,
                        input string tag);
    int lat;
    in0 = a; in1 = b; borrow_in = bi;
    if (sel) start1 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start1 = 1'b0;
    lat = 0;
    chk({tag, ":busy"}, sel ? busy1 : busy, 1);
    while (!(sel ? done1 : done) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":lat"}, lat, exp_lat);
    chk({tag, ":sub"}, sel ? sub1 : sub, exp_sub);
    chk({tag, ":bo"},  sel ? borrow_out1 : borrow_out, exp_bo);
    chk({tag, ":ov"},  sel ? overflow1 : overflow, exp_ov);
    chk({tag, ":z"},   sel ? zero1 : zero, exp_z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int lat;
    bit seen;

    // Reset with random inputs and start asserted.
    rst_n = 1'b0; start = 1'b1; start1 = 1'b1; borrow_in = 1'b1;
    in0 = $urandom; in1 = $urandom;
    repeat (3) @(negedge clk);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:sub", sub, 0);
    chk("rst:flags", {borrow_out, overflow, zero}, 0);
    chk("rst:busy1", busy1, 0);
    chk("rst:sub1", sub1, 0);
    start = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 32'h0000_0005, 32'h0000_0003, 0, 32'h0000_0002, 0, 0, 0, 4, "basic");
    run_op(0, 32'h0000_0000, 32'h0000_0001, 0, 32'hFFFF_FFFF, 1, 0, 0, 4, "ripple");
    run_op(0, 32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 0, 1, 0, 4, "ovf_neg");
    run_op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 1, 0, 4, "ovf_pos");
    run_op(0, 32'h1234_5678, 32'h1234_5678, 1, 32'hFFFF_FFFF, 1, 0, 0, 4, "bin");
    run_op(0, 32'h1234_5678, 32'h1234_5678, 0, 32'h0000_0000, 0, 0, 1, 4, "zero");

    // START at the 2nd busy cycle with new operands must be ignored.
    in0 = 32'h0000_0005; in1 = 32'h0000_0003; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; in0 = 32'hAAAA_0000; in1 = 32'h0000_0001; borrow_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ign:lat", lat, 4);
    chk("ign:sub", sub, 32'h0000_0002);
    chk("ign:bo", borrow_out, 0);
    @(negedge clk);
    chk("ign:idle", busy, 0);

    // START held high: back-to-back ops, one DONE every 5 cycles.
    in0 = 32'h0000_0010; in1 = 32'h0000_0001; borrow_in = 1'b0; start = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("held:first", done, 1);
    chk("held:sub1", sub, 32'h0000_000F);
    in0 = 32'h0000_0020;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("held:gap", cyc, 5);
    chk("held:sub2", sub, 32'h0000_001F);
    @(negedge clk);
    chk("held:idle", busy, 0);

    // Reset at the 3rd busy cycle aborts the run.
    in0 = 32'h0000_0009; in1 = 32'h0000_0004; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort:busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort:busy", busy, 0);
    chk("abort:done", done, 0);
    chk("abort:sub", sub, 0);
    chk("abort:flags", {borrow_out, overflow, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort:no_done", seen, 0);
    run_op(0, 32'h0000_0009, 32'h0000_0004, 0, 32'h0000_0005, 0, 0, 0, 4, "after_abort");

    // Single-digit instance.
    run_op(1, 32'h0000_0005, 32'h0000_0003, 0, 32'h0000_0002, 0, 0, 0, 1, "d32_basic");
    run_op(1, 32'h0000_0000, 32'h0000_0001, 0, 32'hFFFF_FFFF, 1, 0, 0, 1, "d32_ripple");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
